shift_add_multiplier: RTL and testbench

Sequential unsigned shift-and-add multiplier. It is the inverse operation of the team's restoring divider, and the two share the same operand width and the same register/adder style. Each multiply takes WIDTH iterations using one WIDTH-bit adder, with a start/done handshake. Its product can be fed back through the divider to self-check the arithmetic datapath.

---
 rtl/shift_add_multiplier_pkg.sv | 20 ++
 rtl/shift_add_multiplier_add_nb.sv | 27 ++
 rtl/shift_add_multiplier.sv | 116 +++++++++++
 tb/tb_shift_add_multiplier.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/shift_add_multiplier_pkg.sv
// Shared definitions for the shift-and-add multiplier. The operand width default
// matches the restoring divider, so products can be checked by dividing them back.
package shift_add_multiplier_pkg;

  localparam int DEFAULT_WIDTH = 4;
  localparam int MIN_WIDTH     = 2;
  localparam int MAX_WIDTH     = 16;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  // Iteration counter width: enough to hold WIDTH-1 plus one guard bit.
  function automatic int count_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/shift_add_multiplier_add_nb.sv
// WIDTH-bit ripple-carry adder built from a chain of full-adder cells; the
// multiplier instantiates one of these for its add-and-shift step.
module add_nb
  import shift_add_multiplier_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH:0] carry;

  assign carry[0] = 1'b0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    logic half;
    assign half         = a[i] ^ b[i];
    assign sum[i]       = half ^ carry[i];
    assign carry[i+1]   = (a[i] & b[i]) | (carry[i] & half);
  end

  assign cout = carry[WIDTH];

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned shift-and-add multiplier: one add-and-shift per cycle over
// WIDTH cycles, start/done handshake, product taken live from {A,Q}.
module shift_add_multiplier
  import shift_add_multiplier_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CNT_W = count_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  if (WIDTH < MIN_WIDTH || WIDTH > MAX_WIDTH) begin : g_bad_width
    $error("shift_add_multiplier: WIDTH out of range");
  end

  state_t           state;
  logic [WIDTH-1:0] m_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] q_reg;
  logic             c_reg;
  logic [CNT_W-1:0] count;

  logic [WIDTH-1:0] addend;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             c_next;

  // A zero addend makes the adder pass A through with no carry, which is the
  // "Q[0]=0" branch of the iteration without a second datapath.
  assign addend = q_reg[0] ? m_reg : '0;

  add_nb #(.WIDTH(WIDTH)) u_add (
    .a    (a_reg),
    .b    (addend),
    .sum  (sum),
    .cout (cout)
  );

  // C is cleared by every shift, so it only ever contributes zero here.
  assign c_next  = cout | c_reg;
  assign product = {a_reg, q_reg};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      m_reg <= '0;
      a_reg <= '0;
      q_reg <= '0;
      c_reg <= 1'b0;
      count <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            m_reg <= multiplicand;
            q_reg <= multiplier;
            a_reg <= '0;
            c_reg <= 1'b0;
            count <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            busy  <= 1'b0;
          end
        end

        RUN: begin
          a_reg <= {c_next, sum[WIDTH-1:1]};
          q_reg <= {sum[0], q_reg[WIDTH-1:1]};
          c_reg <= 1'b0;
          count <= count + 1'b1;
          if (count == LAST) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end

        DONE: begin
          done <= 1'b0;
          if (start) begin
            m_reg <= multiplicand;
            q_reg <= multiplier;
            a_reg <= '0;
            c_reg <= 1'b0;
            count <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end

        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Scoreboard bench for shift_add_multiplier (WIDTH=4): the driver queues the
// expected product and done cycle; a negedge monitor pops and compares.
module tb_shift_add_multiplier;

  localparam int W = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [W-1:0]   multiplicand = '0;
  logic [W-1:0]   multiplier = '0;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;

  typedef struct {
    int prod;
    int due;
    int m;
    int q;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  shift_add_multiplier #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .done         (done),
    .product      (product)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_done: got done with product %0d expected no pulse (t=%0t)",
                 product, $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check($sformatf("product_%0dx%0d", e.m, e.q), int'(product), e.prod);
        check("done_latency", cyc, e.due);
        check("busy_in_done", int'(busy), 0);
        // Divider round trip: product / M must give back Q with zero remainder.
        if (e.m != 0 && int'(product) < 16) begin
          check("div_quotient", int'(product) / e.m, e.q);
          check("div_remainder", int'(product) % e.m, 0);
        end
      end
    end
  end

  task automatic push_exp(input int m, input int q);
    exp_t e;
    e.prod = m * q;
    e.due  = cyc + W;
    e.m    = m;
    e.q    = q;
    sb.push_back(e);
  endtask

  task automatic issue(input int m, input int q);
    int guard = 0;
    while (busy && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (busy) check("issue_wait_timeout", 1, 0);
    multiplicand = W'(m);
    multiplier   = W'(q);
    start        = 1'b1;
    @(posedge clk);
    #1;
    push_exp(m, q);
    start = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    while (sb.size() != 0 && guard < 40) begin
      @(negedge clk);
      #1;
      guard++;
    end
    if (sb.size() != 0) check("drain_timeout", sb.size(), 0);
  endtask

  initial begin
    int n;
    int k;
    int off;
    int p;

    // Reset state
    #12;
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_product", int'(product), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 5*3, with busy counted across the run
    issue(5, 3);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) break;
      if (busy) n++;
    end
    check("busy_cycles", n, W);
    drain();

    issue(15, 15);
    drain();
    issue(0, 9);
    drain();

    // Start during RUN is ignored
    issue(6, 7);
    @(negedge clk);
    @(negedge clk);
    multiplicand = 4'd2;
    multiplier   = 4'd2;
    start        = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    drain();
    repeat (3) @(negedge clk);

    // Start held high: second request accepted on the DONE cycle
    multiplicand = 4'd3;
    multiplier   = 4'd4;
    start        = 1'b1;
    @(posedge clk);
    #1;
    push_exp(3, 4);
    n = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!done) check("b2b_done_timeout", 0, 1);
    multiplicand = 4'd9;
    multiplier   = 4'd11;
    @(posedge clk);
    #1;
    push_exp(9, 11);
    start = 1'b0;
    drain();
    repeat (2) @(negedge clk);

    // Asynchronous reset between edges mid-RUN
    issue(5, 5);
    @(negedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_busy", int'(busy), 0);
    check("async_rst_done", int'(done), 0);
    check("async_rst_product", int'(product), 0);
    sb.delete();
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (W + 4) @(negedge clk);
    issue(7, 7);
    drain();

    // Randomised-order sweep of all operand pairs
    k   = int'($urandom_range(0, 127)) * 2 + 1;
    off = int'($urandom_range(0, 255));
    for (int i = 0; i < 256; i++) begin
      p = (i * k + off) & 255;
      issue(p >> 4, p & 15);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    drain();
    check("scoreboard_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
